// File: rtl/fp32_result_checker_if.sv
// Bus bundle for the fp32 result checker: run control, expected-value
// push stream, DUT result stream and the run status outputs.
interface fp32_result_checker_if;
    logic        i_start;
    logic [15:0] i_num_vectors;
    logic        i_exp_valid;
    logic [31:0] i_exp_data;
    logic        o_exp_ready;
    logic        i_res_valid;
    logic [31:0] i_res_data;
    logic [15:0] o_pass_cnt;
    logic [15:0] o_fail_cnt;
    logic        o_mismatch_valid;
    logic [15:0] o_mismatch_idx;
    logic        o_done;
    logic        o_error;

    // Driver side: stimulus source pushing expectations and results
    modport master (
        output i_start, i_num_vectors, i_exp_valid, i_exp_data,
               i_res_valid, i_res_data,
        input  o_exp_ready, o_pass_cnt, o_fail_cnt, o_mismatch_valid,
               o_mismatch_idx, o_done, o_error
    );

    // Checker side
    modport slave (
        input  i_start, i_num_vectors, i_exp_valid, i_exp_data,
               i_res_valid, i_res_data,
        output o_exp_ready, o_pass_cnt, o_fail_cnt, o_mismatch_valid,
               o_mismatch_idx, o_done, o_error
    );
endinterface

// File: rtl/fp32_result_checker.sv
// Compares a stream of fp32 results against expected values queued in a
// small FIFO, with NaN/Inf handling and an ULP tolerance on finite values.
// Keeps pass/fail counts for a run of a programmed length.
module fp32_result_checker #(
    parameter int FIFO_DEPTH = 8,
    parameter int ULP_TOL    = 0
) (
    input logic                   s_clk,
    input logic                   s_rst,
    fp32_result_checker_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_q, state_d;
    logic [31:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         full, empty, push, pop, res_evt;
    logic [31:0]  head;
    logic [15:0]  num_q, pass_cnt, fail_cnt, res_idx, mm_idx;
    logic         mm_valid, error_q;
    logic         nan_e, nan_r, inf_e, inf_r, value_pass, result_pass;
    logic signed [32:0] key_e, key_r;
    logic signed [33:0] key_diff;
    logic [33:0]  abs_diff;
    logic [16:0]  total_next;
    logic         last_result;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
    endfunction

    // Sign-magnitude to two's complement so adjacent floats differ by 1 and +0 == -0
    function automatic logic signed [32:0] to_key(input logic [31:0] v);
        logic signed [32:0] mag;
        mag = {2'b00, v[30:0]};
        return v[31] ? -mag : mag;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign push    = bus.i_exp_valid && !full;
    assign res_evt = (state_q == RUN) && bus.i_res_valid && !bus.i_start;
    assign pop     = res_evt && !empty;
    assign head    = fifo_mem[rd_ptr[AW-1:0]];

    assign nan_e    = is_nan(head);
    assign nan_r    = is_nan(bus.i_res_data);
    assign inf_e    = is_inf(head);
    assign inf_r    = is_inf(bus.i_res_data);
    assign key_e    = to_key(head);
    assign key_r    = to_key(bus.i_res_data);
    assign key_diff = {key_e[32], key_e} - {key_r[32], key_r};
    assign abs_diff = key_diff[33] ? 34'(-key_diff) : 34'(key_diff);

    assign total_next  = {1'b0, pass_cnt} + {1'b0, fail_cnt} + 17'd1;
    assign last_result = (total_next == {1'b0, num_q});

    // Pass/fail decision for the FIFO head against the incoming result
    always_comb begin
        value_pass = 1'b0;
        if (nan_e && nan_r) begin
            value_pass = 1'b1;
        end else if (nan_e || nan_r) begin
            value_pass = 1'b0;
        end else if (inf_e || inf_r) begin
            value_pass = (head == bus.i_res_data);
        end else begin
            value_pass = (abs_diff <= 34'(ULP_TOL));
        end
        result_pass = !empty && value_pass;
    end

    // Expected-value storage; contents need no reset since pointers define validity
    always_ff @(posedge s_clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= bus.i_exp_data;
        end
    end

    // FIFO pointers; a push and a pop in the same cycle both advance
    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Run state register
    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: start (re)arms from any state; the final result ends the run
    always_comb begin
        state_d = state_q;
        if (bus.i_start) begin
            state_d = (bus.i_num_vectors == 16'd0) ? DONE : RUN;
        end else if (res_evt && last_result) begin
            state_d = DONE;
        end
    end

    // Counters, result index, sticky error and the mismatch pulse
    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            num_q    <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            res_idx  <= '0;
            mm_idx   <= '0;
            mm_valid <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            mm_valid <= 1'b0;
            if (bus.i_start) begin
                num_q    <= bus.i_num_vectors;
                pass_cnt <= '0;
                fail_cnt <= '0;
                res_idx  <= '0;
                error_q  <= 1'b0;
            end else if (res_evt) begin
                if (result_pass) begin
                    pass_cnt <= sat_inc(pass_cnt);
                end else begin
                    fail_cnt <= sat_inc(fail_cnt);
                    mm_valid <= 1'b1;
                    mm_idx   <= res_idx;
                end
                if (empty) error_q <= 1'b1;
                res_idx <= sat_inc(res_idx);
            end
        end
    end

    assign bus.o_exp_ready      = !full;
    assign bus.o_pass_cnt       = pass_cnt;
    assign bus.o_fail_cnt       = fail_cnt;
    assign bus.o_mismatch_valid = mm_valid;
    assign bus.o_mismatch_idx   = mm_idx;
    assign bus.o_done           = (state_q == DONE);
    assign bus.o_error          = error_q;
endmodule

// File: tb/tb_fp32_result_checker.sv
// Bench for fp32_result_checker: two instances (ULP_TOL 0 and 1) driven by
// the same directed vectors, each checked every cycle against a queue-based
// reference model, plus hand-computed literal expectations.
module tb_fp32_result_checker;
    logic        clk = 1'b0;
    logic        s_rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num = '0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_data = '0;
    logic        res_valid = 1'b0;
    logic [31:0] res_data = '0;

    logic        d_ready [2];
    logic [15:0] d_pass  [2];
    logic [15:0] d_fail  [2];
    logic        d_mv    [2];
    logic [15:0] d_midx  [2];
    logic        d_done  [2];
    logic        d_err   [2];

    int checks = 0;
    int errors = 0;

    // Reference model state per lane: state 0 idle, 1 running, 2 done
    logic [31:0] m_q [2][$];
    int m_state [2];
    int m_pass [2];
    int m_fail [2];
    int m_err [2];
    int m_mv [2];
    int m_midx [2];
    int m_idx [2];
    int m_num [2];

    // Free-running clock
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : lane
        fp32_result_checker_if bus_if ();

        assign bus_if.i_start       = start;
        assign bus_if.i_num_vectors = num;
        assign bus_if.i_exp_valid   = exp_valid;
        assign bus_if.i_exp_data    = exp_data;
        assign bus_if.i_res_valid   = res_valid;
        assign bus_if.i_res_data    = res_data;

        assign d_ready[g] = bus_if.o_exp_ready;
        assign d_pass[g]  = bus_if.o_pass_cnt;
        assign d_fail[g]  = bus_if.o_fail_cnt;
        assign d_mv[g]    = bus_if.o_mismatch_valid;
        assign d_midx[g]  = bus_if.o_mismatch_idx;
        assign d_done[g]  = bus_if.o_done;
        assign d_err[g]   = bus_if.o_error;

        fp32_result_checker #(.FIFO_DEPTH(8), .ULP_TOL(g)) dut (
            .s_clk (clk),
            .s_rst (s_rst),
            .bus   (bus_if.slave)
        );
    end

    // Floating-point match rule: NaN pairs match, Inf needs exact bits, else ULP distance
    function automatic bit fp_pass(input logic [31:0] e, input logic [31:0] r, input int tol);
        bit en, rn;
        longint ke, kr, d;
        en = (e[30:23] == 8'hFF) && (e[22:0] != 0);
        rn = (r[30:23] == 8'hFF) && (r[22:0] != 0);
        if (en && rn) return 1'b1;
        if (en || rn) return 1'b0;
        if (e[30:23] == 8'hFF || r[30:23] == 8'hFF) return (e == r);
        ke = longint'(e[30:0]);
        kr = longint'(r[30:0]);
        if (e[31]) ke = -ke;
        if (r[31]) kr = -kr;
        d = ke - kr;
        if (d < 0) d = -d;
        return d <= longint'(tol);
    endfunction

    // Reference model, advanced on the same edges the DUT sees
    always @(posedge clk or negedge s_rst) begin
        if (!s_rst) begin
            for (int l = 0; l < 2; l++) begin
                m_q[l].delete();
                m_state[l] <= 0;
                m_pass[l] <= 0;
                m_fail[l] <= 0;
                m_err[l] <= 0;
                m_mv[l] <= 0;
                m_midx[l] <= 0;
                m_idx[l] <= 0;
                m_num[l] <= 0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                automatic int sz = m_q[l].size();
                automatic bit ok = 1'b0;
                automatic int np = m_pass[l];
                automatic int nf = m_fail[l];
                m_mv[l] <= 0;
                if (start) begin
                    m_num[l] <= int'(num);
                    m_pass[l] <= 0;
                    m_fail[l] <= 0;
                    m_err[l] <= 0;
                    m_idx[l] <= 0;
                    m_state[l] <= (num == 0) ? 2 : 1;
                end else if (m_state[l] == 1 && res_valid) begin
                    if (sz == 0) m_err[l] <= 1;
                    else ok = fp_pass(m_q[l].pop_front(), res_data, l);
                    if (ok) begin
                        np = (np < 65535) ? np + 1 : np;
                    end else begin
                        nf = (nf < 65535) ? nf + 1 : nf;
                        m_mv[l] <= 1;
                        m_midx[l] <= m_idx[l];
                    end
                    m_pass[l] <= np;
                    m_fail[l] <= nf;
                    m_idx[l] <= m_idx[l] + 1;
                    if (np + nf == m_num[l]) m_state[l] <= 2;
                end
                if (exp_valid && sz < 8) m_q[l].push_back(exp_data);
            end
        end
    end

    task automatic check_output(input string name, input int l, input logic [31:0] actual,
                                input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s lane%0d actual=%h required=%h", name, l, actual, required);
        end
    endtask

    task automatic compare_all();
        for (int l = 0; l < 2; l++) begin
            check_output("model_ready", l, 32'(d_ready[l]), (m_q[l].size() < 8) ? 1 : 0);
            check_output("model_pass", l, 32'(d_pass[l]), m_pass[l]);
            check_output("model_fail", l, 32'(d_fail[l]), m_fail[l]);
            check_output("model_done", l, 32'(d_done[l]), (m_state[l] == 2) ? 1 : 0);
            check_output("model_error", l, 32'(d_err[l]), m_err[l]);
            check_output("model_mm_valid", l, 32'(d_mv[l]), m_mv[l]);
            if (m_mv[l] != 0) check_output("model_mm_idx", l, 32'(d_midx[l]), m_midx[l]);
        end
    endtask

    // Drive one cycle of inputs from a falling edge, then compare after the rising edge
    task automatic apply_stimulus(input logic st, input logic [15:0] n, input logic ev,
                                  input logic [31:0] ed, input logic rv, input logic [31:0] rd);
        start = st;
        num = n;
        exp_valid = ev;
        exp_data = ed;
        res_valid = rv;
        res_data = rd;
        @(negedge clk);
        start = 1'b0;
        exp_valid = 1'b0;
        res_valid = 1'b0;
        compare_all();
    endtask

    task automatic push(input logic [31:0] d);
        apply_stimulus(1'b0, 16'd0, 1'b1, d, 1'b0, 32'd0);
    endtask

    task automatic result(input logic [31:0] d);
        apply_stimulus(1'b0, 16'd0, 1'b0, 32'd0, 1'b1, d);
    endtask

    task automatic run(input logic [15:0] n);
        apply_stimulus(1'b1, n, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic expect_both(input string name, input logic [15:0] p, input logic [15:0] f,
                               input logic dn, input logic er);
        for (int l = 0; l < 2; l++) begin
            check_output({name, "_pass"}, l, 32'(d_pass[l]), 32'(p));
            check_output({name, "_fail"}, l, 32'(d_fail[l]), 32'(f));
            check_output({name, "_done"}, l, 32'(d_done[l]), 32'(dn));
            check_output({name, "_error"}, l, 32'(d_err[l]), 32'(er));
        end
    endtask

    // Directed scenario sequence
    initial begin
        repeat (2) @(negedge clk);
        compare_all();
        expect_both("reset", 16'd0, 16'd0, 1'b0, 1'b0);
        check_output("reset_ready", 0, 32'(d_ready[0]), 32'd1);
        s_rst = 1'b1;

        // Exact match on a single vector; push on the first edge after reset
        push(32'h408C0000);
        run(16'd1);
        result(32'h408C0000);
        expect_both("exact", 16'd1, 16'd0, 1'b1, 1'b0);
        result(32'h408C0000);
        expect_both("ignored_in_done", 16'd1, 16'd0, 1'b1, 1'b0);

        // One ULP off: lane 0 fails with index 0, lane 1 passes
        push(32'h3F800000);
        run(16'd1);
        result(32'h3F800001);
        check_output("ulp0_fail", 0, 32'(d_fail[0]), 32'd1);
        check_output("ulp0_mm_valid", 0, 32'(d_mv[0]), 32'd1);
        check_output("ulp0_mm_idx", 0, 32'(d_midx[0]), 32'd0);
        check_output("ulp1_pass", 1, 32'(d_pass[1]), 32'd1);
        check_output("ulp1_mm_valid", 1, 32'(d_mv[1]), 32'd0);
        apply_stimulus(1'b0, 16'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_output("ulp0_pulse_end", 0, 32'(d_mv[0]), 32'd0);

        // Signed zeros and differing NaN payloads both pass
        push(32'h00000000);
        push(32'h7FC00000);
        run(16'd2);
        result(32'h80000000);
        result(32'h7FC00001);
        expect_both("zero_nan", 16'd2, 16'd0, 1'b1, 1'b0);

        // Two ULPs, Inf against largest finite, and one ULP across an exponent step
        push(32'h3F800000);
        push(32'h7F800000);
        push(32'h3F800000);
        run(16'd3);
        result(32'h3F800002);
        result(32'h7F7FFFFF);
        result(32'h3F7FFFFF);
        check_output("tol_fail", 0, 32'(d_fail[0]), 32'd3);
        check_output("tol_mm_idx", 0, 32'(d_midx[0]), 32'd2);
        check_output("tol_pass", 1, 32'(d_pass[1]), 32'd1);
        check_output("tol_fail", 1, 32'(d_fail[1]), 32'd2);

        // Result with nothing queued
        run(16'd1);
        result(32'h40000000);
        expect_both("empty", 16'd0, 16'd1, 1'b1, 1'b1);

        // Zero-length run completes immediately and clears the error
        run(16'd0);
        expect_both("zero_len", 16'd0, 16'd0, 1'b1, 1'b0);

        // Fill past capacity: ready drops after eight pushes, ninth is dropped
        for (int i = 0; i < 8; i++) push(32'h3F800000 + 32'(i));
        check_output("full_ready", 0, 32'(d_ready[0]), 32'd0);
        push(32'h3F800008);
        run(16'd8);
        for (int i = 0; i < 8; i++) result(32'h3F800000 + 32'(i));
        expect_both("full_run", 16'd8, 16'd0, 1'b1, 1'b0);
        check_output("drained_ready", 0, 32'(d_ready[0]), 32'd1);
        run(16'd1);
        result(32'h3F800008);
        expect_both("dropped", 16'd0, 16'd1, 1'b1, 1'b1);

        // Push and pop in the same cycle
        push(32'h41200000);
        run(16'd2);
        apply_stimulus(1'b0, 16'd0, 1'b1, 32'h41A00000, 1'b1, 32'h41200000);
        result(32'h41A00000);
        expect_both("push_pop", 16'd2, 16'd0, 1'b1, 1'b0);

        // No bypass: a value pushed alongside a result is not compared with it
        run(16'd1);
        apply_stimulus(1'b0, 16'd0, 1'b1, 32'hC0490FDB, 1'b1, 32'hC0490FDB);
        expect_both("no_bypass", 16'd0, 16'd1, 1'b1, 1'b1);
        run(16'd1);
        result(32'hC0490FDB);
        expect_both("kept", 16'd1, 16'd0, 1'b1, 1'b0);

        // Restart mid-run keeps the queued expectation
        push(32'h3DCCCCCD);
        push(32'h3E4CCCCD);
        run(16'd2);
        result(32'h3DCCCCCD);
        check_output("pre_restart_pass", 0, 32'(d_pass[0]), 32'd1);
        run(16'd1);
        expect_both("restart", 16'd0, 16'd0, 1'b0, 1'b0);
        result(32'h3E4CCCCD);
        expect_both("restart_done", 16'd1, 16'd0, 1'b1, 1'b0);

        // Asynchronous reset mid-run flushes everything
        push(32'h42280000);
        push(32'h42290000);
        push(32'h422A0000);
        run(16'd3);
        result(32'h42280000);
        check_output("mid_pass", 0, 32'(d_pass[0]), 32'd1);
        #2 s_rst = 1'b0;
        #1;
        compare_all();
        expect_both("async_rst", 16'd0, 16'd0, 1'b0, 1'b0);
        check_output("async_rst_ready", 1, 32'(d_ready[1]), 32'd1);
        check_output("async_rst_mm", 1, 32'(d_mv[1]), 32'd0);
        @(negedge clk);
        s_rst = 1'b1;
        run(16'd1);
        result(32'h42290000);
        expect_both("flushed", 16'd0, 16'd1, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
